// File: rtl/pkt_rr_arb_pkg.sv
// Shared types and helpers for the packet round-robin arbiter and its picker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pkt_rr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width for an n-entry vector; never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pkt_rr_arb_rr_pick.sv
// Rotating-priority finder: first set bit of eligible at or above base, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides what to do with the winner.
module rr_pick
  import pkt_rr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      base,
  output logic [IW-1:0]      winner,
  output logic               none
);

  logic [IW:0]   pos;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest eligible port above base wins.
  always_comb begin
    winner = '0;
    none   = 1'b1;
    pos    = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, base} + (IW+1)'(k);
      // explicit wrap so non-power-of-two NUM_REQ works
      if (pos >= (IW+1)'(NUM_REQ)) begin
        pos = pos - (IW+1)'(NUM_REQ);
      end
      idx = pos[IW-1:0];
      if (eligible[idx]) begin
        winner = idx;
        none   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arb.sv
// Round-robin arbiter sharing one registered single-beat packet bus among NUM_REQ sources.
// Latency: a beat accepted at edge T is on out_* for the cycle after T; first beat one cycle after arbitration.
// Backpressure: per-port req_rdy only while granted; the shared bus is push-only with no backpressure.
module pkt_rr_arb
  import pkt_rr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_WD   = 7,
  parameter int DATA_WD   = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         cfg_en,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*ADDR_WD-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WD-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic                       out_vld,
  output logic [ADDR_WD-1:0]         out_addr,
  output logic [DATA_WD-1:0]         out_data,
  output logic                       busy
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic [ADDR_WD-1:0] addr;
    logic [DATA_WD-1:0] data;
  } beat_t;

  state_t             state;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      rr_base;
  logic [BW-1:0]      burst_cnt;

  logic [NUM_REQ-1:0] eligible;
  logic [IW-1:0]      nxt_base;
  logic [IW-1:0]      pick_base;
  logic [IW-1:0]      pick_win;
  logic               pick_none;
  logic               gnt_vld;
  logic               gnt_en;
  logic               xfer;
  logic               last_beat;
  logic               end_grant;
  beat_t              sel_beat;

  assign eligible  = req_vld & cfg_en;
  assign busy      = (state == GRANT);
  assign xfer      = busy && gnt_vld && gnt_en;
  assign last_beat = (burst_cnt == BW'(MAX_BURST - 1));
  // A grant ends on its last beat, when the source goes quiet, or when it is disabled.
  assign end_grant = busy && ((xfer && last_beat) || !gnt_vld || !gnt_en);
  assign nxt_base  = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
  // While granted, re-arbitration searches from the port after the current one,
  // so the current port only wins again when it is the sole eligible port.
  assign pick_base = busy ? nxt_base : rr_base;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .eligible (eligible),
    .base     (pick_base),
    .winner   (pick_win),
    .none     (pick_none)
  );

  // Mux the granted port's valid, enable and beat fields.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_en   = 1'b0;
    sel_beat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        gnt_vld       = req_vld[i];
        gnt_en        = cfg_en[i];
        sel_beat.addr = req_addr[i*ADDR_WD +: ADDR_WD];
        sel_beat.data = req_data[i*DATA_WD +: DATA_WD];
      end
    end
  end

  // Ready comes from grant registers and the enable mask only, never from req_vld.
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy[i] = busy && (gnt_idx == IW'(i)) && cfg_en[i];
    end
  end

  // Register the accepted beat onto the shared bus; fields hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      out_vld <= xfer;
      if (xfer) begin
        out_addr <= sel_beat.addr;
        out_data <= sel_beat.data;
      end
    end
  end

  // Grant FSM: pick from IDLE, then count beats and hand over without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      rr_base   <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!pick_none) begin
            state     <= GRANT;
            gnt_idx   <= pick_win;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (end_grant) begin
            rr_base   <= nxt_base;
            burst_cnt <= '0;
            if (pick_none) begin
              state <= IDLE;
            end else begin
              gnt_idx <= pick_win;
            end
          end else if (xfer) begin
            burst_cnt <= burst_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Self-checking bench for pkt_rr_arb: directed sources, expected-beat scoreboard, negedge monitor.
// Latency: n/a.
// Backpressure: sources hold each beat until the DUT's req_rdy accepts it.
module tb_pkt_rr_arb;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    cfg_en;
  logic [NR-1:0]    req_vld;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_rdy;
  logic             out_vld;
  logic [AW-1:0]    out_addr;
  logic [DW-1:0]    out_data;
  logic             busy;

  pkt_rr_arb #(
    .NUM_REQ   (NR),
    .ADDR_WD   (AW),
    .DATA_WD   (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .req_vld  (req_vld),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .out_vld  (out_vld),
    .out_addr (out_addr),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [AW+DW-1:0] exp_q[$];
  int               n_chk = 0;
  int               n_err = 0;
  int               run_cur = 0;
  int               run_last = 0;
  logic [NR-1:0]    rdy_or;

  logic [AW-1:0]    s_addr[NR][16];
  logic [DW-1:0]    s_data[NR][16];
  int               s_cnt[NR];
  int               s_ptr[NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic src(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (s_ptr[p] == s_cnt[p]) begin
      s_ptr[p] = 0;
      s_cnt[p] = 0;
    end
    s_addr[p][s_cnt[p]] = a;
    s_data[p][s_cnt[p]] = d;
    s_cnt[p]++;
  endtask

  task automatic expect_beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Drive each source's head beat, note handshakes, cross one rising edge.
  task automatic step();
    logic [NR-1:0] acc;
    for (int i = 0; i < NR; i++) begin
      if (s_ptr[i] < s_cnt[i]) begin
        req_vld[i]              = 1'b1;
        req_addr[i*AW +: AW]    = s_addr[i][s_ptr[i]];
        req_data[i*DW +: DW]    = s_data[i][s_ptr[i]];
      end else begin
        req_vld[i] = 1'b0;
      end
    end
    #1;
    acc    = req_vld & req_rdy;
    rdy_or = rdy_or | req_rdy;
    @(posedge clk);
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) s_ptr[i]++;
    end
    #1;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) begin
      if (cfg_en[i] && (s_ptr[i] < s_cnt[i])) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((pending() || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_drain: timed out with %0d beats outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    step();
    step();
  endtask

  // Monitor: every bus beat must match the next expected beat in order.
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (out_vld === 1'b1) begin
        run_cur++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL beat: got unexpected 0x%0h, want no beat", {out_addr, out_data});
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_addr, out_data}, e);
        end
      end else begin
        if (run_cur != 0) run_last = run_cur;
        run_cur = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_en   = 4'hF;
    req_vld  = '0;
    req_addr = '0;
    req_data = '0;
    rdy_or   = '0;
    for (int i = 0; i < NR; i++) begin
      s_cnt[i] = 0;
      s_ptr[i] = 0;
    end

    // Power-on reset state
    #2;
    chk("rst0_vld",  out_vld, 0);
    chk("rst0_rdy",  req_rdy, 0);
    chk("rst0_busy", busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single port: port 2, three back-to-back beats
    src(2, 7'h05, 32'h11);
    src(2, 7'h05, 32'h22);
    src(2, 7'h05, 32'h33);
    expect_beat(7'h05, 32'h11);
    expect_beat(7'h05, 32'h22);
    expect_beat(7'h05, 32'h33);
    step();
    chk("t1_rdy_grant", req_rdy, 4'b0100);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_lat_vld", out_vld, 1);
    chk("t1_lat_data", out_data, 32'h11);
    drain("t1");
    chk("t1_run", run_last, 3);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rdy", req_rdy, 0);

    // Mid-simulation reset clears held bus fields without a clock edge
    rst = 1'b1;
    #1;
    chk("rst1_vld",  out_vld, 0);
    chk("rst1_addr", out_addr, 0);
    chk("rst1_data", out_data, 0);
    chk("rst1_rdy",  req_rdy, 0);
    chk("rst1_busy", busy, 0);
    step();
    rst = 1'b0;

    // Full contention: grants 0,1,2,3,0,1,2,3 with 4 beats each
    for (int p = 0; p < NR; p++) begin
      for (int b = 0; b < 8; b++) src(p, AW'(16 + p), DW'(256 * p + b));
    end
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NR; p++) begin
        for (int b = 0; b < MB; b++) expect_beat(AW'(16 + p), DW'(256 * p + r * MB + b));
      end
    end
    step();
    chk("t2_rdy_first", req_rdy, 4'b0001);
    repeat (4) step();
    chk("t2_rdy_switch", req_rdy, 4'b0010);
    chk("t2_vld_switch", out_vld, 1);
    drain("t2");
    chk("t2_run", run_last, 32);

    // Masking: port 2 disabled, grant order 0,1,3,0
    cfg_en = 4'b1011;
    rdy_or = '0;
    for (int b = 0; b < 8; b++) src(0, 7'h20, DW'(32'h3000 + b));
    for (int b = 0; b < 4; b++) src(1, 7'h21, DW'(32'h3100 + b));
    for (int b = 0; b < 4; b++) src(2, 7'h22, DW'(32'h3200 + b));
    for (int b = 0; b < 4; b++) src(3, 7'h23, DW'(32'h3300 + b));
    for (int b = 0; b < 4; b++) expect_beat(7'h20, DW'(32'h3000 + b));
    for (int b = 0; b < 4; b++) expect_beat(7'h21, DW'(32'h3100 + b));
    for (int b = 0; b < 4; b++) expect_beat(7'h23, DW'(32'h3300 + b));
    for (int b = 4; b < 8; b++) expect_beat(7'h20, DW'(32'h3000 + b));
    drain("t3");
    chk("t3_rdy2_never", rdy_or[2], 0);
    chk("t3_run", run_last, 16);
    s_ptr[2] = s_cnt[2];
    cfg_en   = 4'hF;

    // Early release: port 1 stops after 2 beats, port 3 takes over next cycle
    src(1, 7'h31, 32'h4100);
    src(1, 7'h31, 32'h4101);
    for (int b = 0; b < 4; b++) src(3, 7'h33, DW'(32'h4300 + b));
    src(0, 7'h30, 32'h4000);
    expect_beat(7'h31, 32'h4100);
    expect_beat(7'h31, 32'h4101);
    for (int b = 0; b < 4; b++) expect_beat(7'h33, DW'(32'h4300 + b));
    expect_beat(7'h30, 32'h4000);
    step();
    chk("t4_rdy_p1", req_rdy, 4'b0010);
    step();
    step();
    step();
    chk("t4_rdy_next", req_rdy, 4'b1000);
    chk("t4_busy", busy, 1);
    drain("t4");

    // Reset during port 0's third beat; restart from port 0
    for (int b = 0; b < 6; b++) src(0, 7'h40, DW'(32'h5000 + b));
    expect_beat(7'h40, 32'h5000);
    expect_beat(7'h40, 32'h5001);
    step();
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_vld",  out_vld, 0);
    chk("t5_rst_addr", out_addr, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_rdy",  req_rdy, 0);
    chk("t5_rst_busy", busy, 0);
    step();
    rst = 1'b0;
    src(2, 7'h42, 32'h5200);
    src(2, 7'h42, 32'h5201);
    for (int b = 3; b < 6; b++) expect_beat(7'h40, DW'(32'h5000 + b));
    expect_beat(7'h42, 32'h5200);
    expect_beat(7'h42, 32'h5201);
    step();
    chk("t5_first_gnt", req_rdy, 4'b0001);
    drain("t5");

    chk("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
